// File: rtl/gcd_req_driver.sv
// Self-contained stimulus source for the gcd unit: two Galois LFSRs feed operand pairs over
// the req port, and each gcd result is folded into a rotating XOR signature.
module gcd_req_driver #(
  parameter int           W       = 16,
  parameter logic [W-1:0] SEED_A  = 16'hACE1,
  parameter logic [W-1:0] SEED_B  = 16'h1D2B,
  parameter int           TIMEOUT = 255
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_start,
  input  logic [7:0]     i_cfg_count,
  output logic [2*W-1:0] o_req_msg,
  output logic           o_req_val,
  input  logic           i_req_rdy,
  input  logic [W-1:0]   i_resp_msg,
  input  logic           i_resp_val,
  output logic           o_resp_rdy,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_error,
  output logic [7:0]     o_resp_count,
  output logic [W-1:0]   o_result_sig
);

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [W-1:0]    POLY   = W'(16'hB400);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     r_state;
  logic [W-1:0]   r_lfsr_a;
  logic [W-1:0]   r_lfsr_b;
  logic [2*W-1:0] r_req_msg;
  logic           r_req_val;
  logic           r_resp_rdy;
  logic           r_busy;
  logic           r_done;
  logic           r_error;
  logic [7:0]     r_remaining;
  logic [7:0]     r_resp_count;
  logic [W-1:0]   r_result_sig;
  logic [WD_W-1:0] r_wdog;

  logic           w_req_fire;
  logic           w_resp_fire;
  logic           w_wdog_exp;
  logic [W-1:0]   w_lfsr_a_nxt;
  logic [W-1:0]   w_lfsr_b_nxt;
  logic [W-1:0]   w_sig_nxt;

  // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
  assign w_lfsr_a_nxt = (r_lfsr_a >> 1) ^ (r_lfsr_a[0] ? POLY : '0);
  assign w_lfsr_b_nxt = (r_lfsr_b >> 1) ^ (r_lfsr_b[0] ? POLY : '0);
  assign w_sig_nxt    = {r_result_sig[W-2:0], r_result_sig[W-1]} ^ i_resp_msg;

  assign w_req_fire  = r_req_val & i_req_rdy;
  assign w_resp_fire = r_resp_rdy & i_resp_val;
  assign w_wdog_exp  = (r_wdog == WD_MAX);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_lfsr_a     <= SEED_A;
      r_lfsr_b     <= SEED_B;
      r_req_msg    <= '0;
      r_req_val    <= 1'b0;
      r_resp_rdy   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_remaining  <= '0;
      r_resp_count <= '0;
      r_result_sig <= '0;
      r_wdog       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_lfsr_a     <= SEED_A;
            r_lfsr_b     <= SEED_B;
            r_req_msg    <= {SEED_B, SEED_A};
            r_remaining  <= i_cfg_count;
            r_resp_count <= '0;
            r_result_sig <= '0;
            r_error      <= 1'b0;
            r_busy       <= 1'b1;
            r_wdog       <= '0;
            if (i_cfg_count == 8'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_req_val <= 1'b1;
              r_state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A handshake in the expiry cycle is still honoured.
          if (w_req_fire) begin
            r_lfsr_a    <= w_lfsr_a_nxt;
            r_lfsr_b    <= w_lfsr_b_nxt;
            r_remaining <= r_remaining - 8'd1;
            r_wdog      <= '0;
            r_req_val   <= 1'b0;
            r_resp_rdy  <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_wdog_exp) begin
            r_error   <= 1'b1;
            r_req_val <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        S_RESP: begin
          if (w_resp_fire) begin
            r_result_sig <= w_sig_nxt;
            r_resp_count <= r_resp_count + 8'd1;
            r_wdog       <= '0;
            r_resp_rdy   <= 1'b0;
            if (r_remaining != 8'd0) begin
              r_req_msg <= {r_lfsr_b, r_lfsr_a};
              r_req_val <= 1'b1;
              r_state   <= S_REQ;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (w_wdog_exp) begin
            r_error    <= 1'b1;
            r_resp_rdy <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_msg    = r_req_msg;
  assign o_req_val    = r_req_val;
  assign o_resp_rdy   = r_resp_rdy;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_resp_count = r_resp_count;
  assign o_result_sig = r_result_sig;

endmodule
